// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;
   localparam int BYTE_W  = 8;
   localparam int INSTR_W = 16;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LEN_HI  = 4'd1,
      LEN_LO  = 4'd2,
      DATA_HI = 4'd3,
      DATA_LO = 4'd4,
      WRITE   = 4'd5,
      CHK     = 4'd6,
      DONE    = 4'd7,
      ERR     = 4'd8
   } state_t;
endpackage

// File: rtl/imem_loader_byte_pack.sv
// Packs two stream bytes MSB-first into an instruction word; with
// IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of the data bytes.
module byte_pack
   import imem_loader_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               hi_en,
   input  logic               lo_en,
   input  logic [BYTE_W-1:0]  data,
   output logic [INSTR_W-1:0] word,
`ifdef IMEM_LOADER_CHECKSUM_EN
   output logic [BYTE_W-1:0]  csum,
`endif
   output logic               word_valid
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= lo_en;
         if (hi_en) word[INSTR_W-1:BYTE_W] <= data;
         if (lo_en) word[BYTE_W-1:0]       <= data;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            csum <= '0;
      else if (clear)          csum <= '0;
      else if (hi_en || lo_en) csum <= csum ^ data;
   end
`endif

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core
// until it is complete. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wen,
   output logic              mem_cen,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0] CAP = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FINAL_ST = CHK;
   logic [BYTE_W-1:0] csum;
`else
   localparam state_t FINAL_ST = DONE;
`endif

   state_t      state;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [16:0] wl_next;
   logic        xfer;
   logic        idle_like;
   logic        last_word;
   logic        word_valid;

   assign xfer      = in_valid && in_ready;
   assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
   assign len_full  = {len[15:8], in_data};
   assign wl_next   = 17'(words_loaded) + 17'd1;
   assign last_word = (wl_next == {1'b0, len});

   always_comb begin
      in_ready = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA_HI, DATA_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:                              in_ready = 1'b1;
`endif
         default:                          in_ready = 1'b0;
      endcase
   end

   assign done     = (state == DONE);
   assign error    = (state == ERR);
   assign cpu_hold = (state != DONE);
   assign mem_wen  = word_valid;
   assign mem_cen  = word_valid;

   byte_pack u_pack (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (start && idle_like),
      .hi_en      (xfer && (state == DATA_HI)),
      .lo_en      (xfer && (state == DATA_LO)),
      .data       (in_data),
      .word       (mem_wdata),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .csum       (csum),
`endif
      .word_valid (word_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         len          <= '0;
         mem_addr     <= '0;
         words_loaded <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  words_loaded <= '0;
                  mem_addr     <= '0;
                  state        <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= in_data;
                  state     <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len[7:0] <= in_data;
                  if (len_full == 16'd0)            state <= FINAL_ST;
                  else if ({1'b0, len_full} > CAP)  state <= ERR;
                  else                              state <= DATA_HI;
               end
            end
            DATA_HI: if (xfer) state <= DATA_LO;
            DATA_LO: if (xfer) state <= WRITE;
            WRITE: begin
               words_loaded <= words_loaded + (ADDR_W+1)'(1);
               // Address stops on the last word so it never wraps at full capacity.
               if (last_word) begin
                  state <= FINAL_ST;
               end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                  state    <= DATA_HI;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (xfer) state <= (in_data == csum) ? DONE : ERR;
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
